muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in EX, directly downstream of the register file, and takes the two read-port values (rs on `a`, rt on `b`) as operands. It runs MULT/MULTU/DIV/DIVU as a 33-cycle sequential operation, handles MTHI/MTLO in a single cycle, and raises `busy` so hazard logic can stall later HI/LO users.

---
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage is the master; the unit exposes HI/LO and its busy/done status.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     clrn,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;

    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        // Magnitudes are plain unsigned, so |0x80000000| stays 0x80000000.
        w_a_abs  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        w_b_abs  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
        w_mul_next = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

        // The trial difference always fits WIDTH bits when the subtraction succeeds.
        w_shift = {r_rem, r_acc[WIDTH-1]};
        w_fits  = w_shift >= {1'b0, r_opb};
        w_diff  = w_shift[WIDTH-1:0] - r_opb;

        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? -r_rem : r_rem;
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    // NOTE: only control state and HI/LO are reset; the datapath is always reloaded on start.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_is_div   <= w_is_div;
                                r_neg_res  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                r_neg_rem  <= w_signed && bus.a[WIDTH-1];
                                r_div_zero <= (bus.b == '0);
                                r_a_raw    <= bus.a;
                                r_opb      <= w_is_div ? w_b_abs : w_a_abs;
                                r_acc      <= {{WIDTH{1'b0}}, w_is_div ? w_a_abs : w_b_abs};
                                r_rem      <= '0;
                                r_cnt      <= '0;
                                r_busy     <= 1'b1;
                                r_state    <= S_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_fits};
                        r_rem            <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div && r_div_zero) begin
                        r_lo <= '1;
                        r_hi <= r_a_raw;
                    end else if (r_is_div) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, multiply, divide corner cases,
// MTHI/MTLO, busy/back-to-back handling and mid-operation abort.
module tb_muldiv_unit;
    logic clk;
    logic clrn;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div, confirm 33 busy cycles with HI/LO held, then the result and done pulse.
    task automatic do_muldiv(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        int n;
        bit hold_bad;
        old_hi = bus.hi;
        old_lo = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        n = 0;
        hold_bad = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.hi !== old_hi || bus.lo !== old_lo || bus.done !== 1'b0) hold_bad = 1;
            tick();
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL %s busy_cycles: got %0d expected 33", name, n);
        end
        checks++;
        if (hold_bad) begin
            errors++; $display("FAIL %s hold_during_calc: got changed expected held", name);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL %s done_pulse: got %b expected 1", name, bus.done);
        end
        checks++;
        if (bus.hi !== exp_hi) begin
            errors++; $display("FAIL %s hi: got %h expected %h", name, bus.hi, exp_hi);
        end
        checks++;
        if (bus.lo !== exp_lo) begin
            errors++; $display("FAIL %s lo: got %h expected %h", name, bus.lo, exp_lo);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL %s done_fall: got %b expected 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state edge %0d: got hi=%h lo=%h busy=%b done=%b expected all zero",
                         i, bus.hi, bus.lo, bus.busy, bus.done);
            end
        end
        bus.start = 1'b0;
        clrn = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_release: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mult();
        do_muldiv("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_muldiv("mult_neg3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_muldiv("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    endtask

    task automatic test_div();
        do_muldiv("div_neg7by2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_muldiv("div_7byneg2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_muldiv("divu_7by0", 3'b011, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        do_muldiv("div_neg7by0", 3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        do_muldiv("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_muldiv("divu_100by7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    task automatic test_mtlo();
        logic [31:0] old_hi;
        old_hi = bus.hi;
        bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h0000_ABCD; bus.b = 32'h0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.lo !== 32'h0000_ABCD) begin
            errors++; $display("FAIL mtlo_lo: got %h expected 0000abcd", bus.lo);
        end
        checks++;
        if (bus.hi !== old_hi || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mtlo_side: got hi=%h busy=%b done=%b expected hi=%h busy=0 done=0",
                               bus.hi, bus.busy, bus.done, old_hi);
        end
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h5555_5555;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'h0000_ABCD) begin
            errors++; $display("FAIL noop_op: got busy=%b done=%b lo=%h expected 0 0 0000abcd",
                               bus.busy, bus.done, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd3; bus.b = 32'd4;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h0000_1234;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            errors++; $display("FAIL mthi_while_busy: got done=%b hi=%h lo=%h expected 1 00000000 0000000c",
                               bus.done, bus.hi, bus.lo);
        end
        // Issue the next multiply while done is high.
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL b2b_busy_cycles: got %0d expected 33", n);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL b2b_result: got done=%b hi=%h lo=%h expected 1 ffffffff fffffffa",
                               bus.done, bus.hi, bus.lo);
        end
        tick();
    endtask

    task automatic test_abort();
        bit saw_done;
        bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        clrn = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++; $display("FAIL abort_state: got busy=%b done=%b hi=%h lo=%h expected all zero",
                               bus.busy, bus.done, bus.hi, bus.lo);
        end
        clrn = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort_no_done: got activity expected idle");
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++; $display("FAIL abort_hilo: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo);
        end
        do_muldiv("divu_after_abort", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        clrn = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mtlo();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
